// File: rtl/hp1349a_pkg.sv
// Shared definitions for the HP1349A parallel display bus (talker and listener ends).
package hp1349a_pkg;

  localparam int HP1349A_DATA_W = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RFD = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    RELEASE  = 3'd4
  } hp1349a_state_e;

endpackage

// File: rtl/hp1349a_bus_tx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hp1349a_bus_tx.sv
// Talker end of the HP1349A display bus: takes words from a valid/ready stream and
// moves each one across the bus with a full LDAV/LRFD four-phase handshake.
module hp1349a_bus_tx
  import hp1349a_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [HP1349A_DATA_W-1:0] in_data,
  output logic                      in_ready,
  output logic [HP1349A_DATA_W-1:0] BUS_DATA,
  output logic                      BUS_LDAV,
  input  logic                      BUS_LRFD,
  output logic                      busy,
  output logic                      timeout,
  input  logic                      timeout_clr,
  output logic [15:0]               words_sent
);

  localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [31:0] TO_LIMIT   = 32'(TIMEOUT_CYCLES);
  localparam bit          TO_ENABLE  = (TIMEOUT_CYCLES != 0);

  hp1349a_state_e            state_q, state_d;
  logic [HP1349A_DATA_W-1:0] data_q, data_d;
  logic                      ldav_q, ldav_d;
  logic [7:0]                setup_cnt_q, setup_cnt_d;
  logic [31:0]               wait_cnt_q, wait_cnt_d;
  logic                      timeout_q, timeout_d;
  logic [15:0]               words_q, words_d;
  logic                      lrfd_s;
  logic [31:0]               wait_inc;
  logic                      to_hit;

  // Reset value 1 keeps the talker treating the listener as not ready until it proves otherwise.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_lrfd_sync (
    .clk(clk),
    .rst(rst),
    .d  (BUS_LRFD),
    .q  (lrfd_s)
  );

  assign wait_inc = wait_cnt_q + 32'd1;
  assign to_hit   = TO_ENABLE && (wait_inc == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ldav_d      = ldav_q;
    setup_cnt_d = setup_cnt_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q & ~timeout_clr;
    words_d     = words_q;

    case (state_q)
      IDLE: begin
        ldav_d = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          state_d = WAIT_RFD;
        end
      end

      WAIT_RFD: begin
        ldav_d = 1'b1;
        if (!lrfd_s) begin
          state_d     = SETUP;
          setup_cnt_d = '0;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      SETUP: begin
        ldav_d = 1'b1;
        if (setup_cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          ldav_d  = 1'b0;
        end else begin
          setup_cnt_d = setup_cnt_q + 8'd1;
        end
      end

      STROBE: begin
        ldav_d = 1'b0;
        if (lrfd_s) begin
          state_d = RELEASE;
          ldav_d  = 1'b1;
          words_d = words_q + 16'd1;
        end else if (to_hit) begin
          // Abandon the word: strobe released, counter untouched.
          timeout_d = 1'b1;
          ldav_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      RELEASE: begin
        ldav_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ldav_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      ldav_q      <= 1'b1;
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ldav_q      <= ldav_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      words_q     <= words_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign BUS_DATA   = data_q;
  assign BUS_LDAV   = ldav_q;
  assign timeout    = timeout_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_hp1349a_bus_tx.sv
// Bench for hp1349a_bus_tx: directed sequence plus a behavioural listener on the bus.
module tb_hp1349a_bus_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [14:0] in_data = '0;
  logic        in_ready;
  logic [14:0] BUS_DATA;
  logic        BUS_LDAV;
  logic        BUS_LRFD = 1'b0;
  logic        busy;
  logic        timeout;
  logic        timeout_clr = 1'b0;
  logic [15:0] words_sent;

  int errors = 0;
  int checks = 0;

  // Listener model state
  int          lst_mode = 0;   // 0 responsive, 1 hold LRFD high, 2 never raise LRFD
  bit          lst_rand = 0;
  int          lst_st = 0;
  int          lst_cnt = 0;
  int          lst_resp = 3;
  int          lst_rdy = 0;
  logic [14:0] cap_q[$];
  logic        h1 = 1'b0, h2 = 1'b0, prev_ldav = 1'b1;
  logic [14:0] held = '0;
  int          mon_bad_fall = 0;
  int          mon_bad_stable = 0;

  hp1349a_bus_tx #(
    .SETUP_CYCLES  (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .BUS_DATA   (BUS_DATA),
    .BUS_LDAV   (BUS_LDAV),
    .BUS_LRFD   (BUS_LRFD),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_clr(timeout_clr),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [14:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 3000; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 15'($urandom);
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // Listener: reacts on falling clock edges, also watches the strobe rules.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_ldav && !BUS_LDAV && (BUS_LRFD || h1 || h2)) mon_bad_fall++;
      if (!BUS_LDAV) begin
        if (prev_ldav) held = BUS_DATA;
        else if (BUS_DATA !== held) mon_bad_stable++;
      end
      h2 = h1;
      h1 = BUS_LRFD;
      prev_ldav = BUS_LDAV;

      if (!rst) begin
        lst_st = 0;
      end else if (lst_mode == 1) begin
        BUS_LRFD = 1'b1;
        lst_st   = 0;
      end else if (lst_mode == 2) begin
        BUS_LRFD = 1'b0;
        lst_st   = 0;
      end else begin
        if (lst_st == 0 && !BUS_LDAV) begin
          lst_st   = 1;
          lst_cnt  = 0;
          lst_resp = lst_rand ? int'($urandom_range(20, 0)) : 3;
        end
        if (lst_st == 1) begin
          if (lst_cnt >= lst_resp) begin
            cap_q.push_back(BUS_DATA);
            BUS_LRFD = 1'b1;
            lst_st   = 2;
          end else begin
            lst_cnt++;
          end
        end else if (lst_st == 2) begin
          if (BUS_LDAV) begin
            lst_st  = 3;
            lst_cnt = 0;
            lst_rdy = lst_rand ? int'($urandom_range(20, 0)) : 0;
          end
        end else if (lst_st == 3) begin
          if (lst_cnt >= lst_rdy) begin
            BUS_LRFD = 1'b0;
            lst_st   = 0;
          end else begin
            lst_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int base;
    int bad;
    bit seen;
    int highs;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ldav", {31'd0, BUS_LDAV}, 32'd1);
    chk("rst_data", {17'd0, BUS_DATA}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_words", {16'd0, words_sent}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // Single word, fixed 3-cycle listener
    send(15'h1ABC);
    chk("single_data", {17'd0, BUS_DATA}, 32'h1ABC);
    chk("single_ldav_e0", {31'd0, BUS_LDAV}, 32'd1);
    highs = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (BUS_LDAV) highs++;
    end
    chk("single_setup_high", highs, 32'd4);
    @(posedge clk);
    #1;
    chk("single_ldav_fall", {31'd0, BUS_LDAV}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (BUS_LRFD) begin
        seen = 1'b1;
        break;
      end
    end
    chk("single_lrfd_rise", {31'd0, seen}, 32'd1);
    #1;
    chk("single_ldav_k0", {31'd0, BUS_LDAV}, 32'd0);
    @(posedge clk);
    #1;
    chk("single_ldav_k1", {31'd0, BUS_LDAV}, 32'd0);
    @(posedge clk);
    #1;
    chk("single_ldav_k2", {31'd0, BUS_LDAV}, 32'd1);
    chk("single_words", {16'd0, words_sent}, 32'd1);
    chk("single_ready_release", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("single_ready_after", {31'd0, in_ready}, 32'd1);
    chk("single_capture", {17'd0, cap_q[cap_q.size()-1]}, 32'h1ABC);

    // Burst of 100 words with random listener delays
    lst_rand       = 1'b1;
    mon_bad_fall   = 0;
    mon_bad_stable = 0;
    base           = cap_q.size();
    for (int i = 0; i < 100; i++) send(15'(i));
    wait_idle("burst_done", 3000);
    bad = 0;
    for (int i = 0; i < 100; i++)
      if (base + i >= cap_q.size() || cap_q[base+i] !== 15'(i)) bad++;
    chk("burst_count", cap_q.size() - base, 32'd100);
    chk("burst_order_bad", bad, 32'd0);
    chk("burst_words", {16'd0, words_sent}, 32'd101);
    chk("burst_fall_while_busy", mon_bad_fall, 32'd0);
    chk("burst_data_stable", mon_bad_stable, 32'd0);

    // Listener holds LRFD high: timeout in WAIT_RFD
    lst_mode = 1;
    repeat (5) @(posedge clk);
    send(15'h2222);
    repeat (49) @(posedge clk);
    #1;
    chk("to_wait_not_yet", {31'd0, timeout}, 32'd0);
    chk("to_wait_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("to_wait_set", {31'd0, timeout}, 32'd1);
    chk("to_wait_idle", {31'd0, in_ready}, 32'd1);
    chk("to_wait_words", {16'd0, words_sent}, 32'd101);
    repeat (3) @(posedge clk);
    #1;
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    @(negedge clk);
    timeout_clr = 1'b1;
    @(posedge clk);
    #1;
    timeout_clr = 1'b0;
    chk("to_clr", {31'd0, timeout}, 32'd0);

    // Listener never raises LRFD: timeout in STROBE
    lst_mode = 2;
    repeat (5) @(posedge clk);
    send(15'h3333);
    repeat (5) @(posedge clk);
    #1;
    chk("to_strobe_low", {31'd0, BUS_LDAV}, 32'd0);
    repeat (49) @(posedge clk);
    #1;
    chk("to_strobe_still_low", {31'd0, BUS_LDAV}, 32'd0);
    @(posedge clk);
    #1;
    chk("to_strobe_ldav_high", {31'd0, BUS_LDAV}, 32'd1);
    chk("to_strobe_set", {31'd0, timeout}, 32'd1);
    chk("to_strobe_idle", {31'd0, busy}, 32'd0);
    chk("to_strobe_words", {16'd0, words_sent}, 32'd101);
    lst_mode = 0;
    send(15'h4444);
    wait_idle("after_to_done", 3000);
    chk("after_to_words", {16'd0, words_sent}, 32'd102);
    chk("after_to_capture", {17'd0, cap_q[cap_q.size()-1]}, 32'h4444);

    // Reset while LDAV is low
    lst_mode = 2;
    repeat (5) @(posedge clk);
    send(15'h5555);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_pre_low", {31'd0, BUS_LDAV}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_ldav", {31'd0, BUS_LDAV}, 32'd1);
    chk("rst_mid_data", {17'd0, BUS_DATA}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_words", {16'd0, words_sent}, 32'd0);
    chk("rst_mid_timeout", {31'd0, timeout}, 32'd0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (BUS_LDAV) highs++;
    end
    chk("rst_no_partial_strobe", highs, 32'd10);

    // Counter wrap
    lst_mode = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    force dut.words_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_q;
    @(posedge clk);
    #1;
    chk("wrap_preload", {16'd0, words_sent}, 32'hFFFF);
    send(15'h6789);
    wait_idle("wrap_done", 3000);
    chk("wrap_words", {16'd0, words_sent}, 32'd0);
    chk("wrap_capture", {17'd0, cap_q[cap_q.size()-1]}, 32'h6789);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hp1349a_bus_tx.md
# hp1349a_bus_tx

Transmitter end of the HP1349A parallel display bus. Accepts 15-bit display words from an upstream valid/ready stream, usually a command generator or a host FIFO, and drives BUS_DATA/BUS_LDAV. It paces the transfer off the listener's BUS_LRFD, one word per full four-phase handshake. It is the talker-side counterpart of the bus interface in the display core and is used both as a host emulator and as a loop-back source for board bring-up.

## Interface
- SETUP_CYCLES, default 4: cycles BUS_DATA is stable before BUS_LDAV falls; legal range 1..255.
- TIMEOUT_CYCLES, default 1_000_000: maximum cycles spent waiting on any BUS_LRFD edge; 0 disables the timeout.
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset), deasserted synchronously to clk upstream.
- in_valid  input  1  upstream word valid.
- in_data  input  15  upstream display word.
- in_ready  output  1  high when a word can be accepted.
- BUS_DATA  output  15  bus data; registered.
- BUS_LDAV  output  1  data-available strobe, active-low; registered.
- BUS_LRFD  input  1  listener ready-for-data, active-low; asynchronous to clk.
- busy  output  1  high whenever state is not IDLE.
- timeout  output  1  sticky; set on a handshake timeout.
- timeout_clr  input  1  single-cycle clear of timeout.
- words_sent  output  16  count of completed handshakes; wraps 0xFFFF -> 0x0000.

## Operation
- BUS_LRFD passes through a 2-flop synchronizer with reset value 1 (not ready). All decisions use the synchronized value lrfd_s.
- Bus handshake:
  - Talker presents data and waits for lrfd_s=0.
  - After the setup time, talker drives LDAV=0.
  - Listener latches the data and raises LRFD; talker sees lrfd_s=1 and drives LDAV=1.
  - Listener lowers LRFD when it is ready again.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch in_data into BUS_DATA and go to WAIT_RFD.
  - WAIT_RFD: wait for lrfd_s=0, then go to SETUP with the cycle counter cleared.
  - SETUP: LDAV=1. After SETUP_CYCLES cycles in SETUP, go to STROBE.
  - STROBE: LDAV=0. When lrfd_s=1, go to RELEASE.
  - RELEASE: LDAV=1. Increment words_sent on entry, then return to IDLE.
- The next word's WAIT_RFD provides the wait for LRFD low, so back-to-back words never re-strobe before the listener is ready again.
- BUS_DATA changes only on acceptance in IDLE. It is held through WAIT_RFD, SETUP, STROBE and RELEASE.
- Timeout:
  - A wait counter runs in WAIT_RFD and STROBE and is cleared on every state change.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, set timeout, force LDAV=1, drop the word (words_sent unchanged) and go to IDLE.
- If a timeout event and timeout_clr occur in the same cycle, the set wins.
- in_data is ignored when in_ready=0.

## Timing
- Reset values:
  - state IDLE, BUS_DATA 0, BUS_LDAV 1, in_ready 1, busy 0, timeout 0, words_sent 0.
  - Synchronizer flops 1, counters 0.
- Reset mid-handshake: on assertion, LDAV returns high asynchronously and the word is lost. No partial strobe is generated after release.
- Latency, with lrfd_s already 0 at the accept edge (edge 0):
  - BUS_DATA valid after edge 0.
  - WAIT_RFD at edge 0, SETUP from edge 1.
  - BUS_LDAV low after edge 1+SETUP_CYCLES.
- Input-to-decision latency is 2 cycles for BUS_LRFD.
  - LDAV rises 3 cycles after BUS_LRFD rises: 2 synchronizer cycles plus the RELEASE register.
  - in_ready returns one cycle after RELEASE.
- Maximum throughput: one word per SETUP_CYCLES + 6 cycles plus listener latency.

## Structure
- Shared package hp1349a_pkg holds:
  - HP1349A_DATA_W = 15.
  - The state enumeration (IDLE, WAIT_RFD, SETUP, STROBE, RELEASE), which is also reusable by the receiver's read state.
- Sub-module sync_2ff (1-bit, parameterized reset value) for BUS_LRFD. Everything else lives inline in hp1349a_bus_tx.

## Test plan
- Single word, SETUP_CYCLES=4, listener model with BUS_LRFD=0 and 3-cycle response:
  - Send in_data=0x1ABC.
  - BUS_DATA=0x1ABC, then LDAV low after 5 cycles.
  - LDAV high 3 cycles after LRFD rises.
  - words_sent=1.
- Burst of 100 words 0x0000..0x0063 with random listener delays 0..20 cycles:
  - Listener captures all 100 words in order.
  - LDAV never falls while lrfd_s=1.
  - BUS_DATA stable across every LDAV-low window.
- Listener holds LRFD=1, TIMEOUT_CYCLES=50:
  - timeout sets after 50 cycles in WAIT_RFD; state returns to IDLE; words_sent unchanged.
  - timeout_clr clears it.
- Listener never raises LRFD during STROBE, TIMEOUT_CYCLES=50:
  - LDAV is forced high at timeout; timeout=1.
  - The next word is accepted and completes normally.
- Reset asserted with LDAV low:
  - LDAV=1 and BUS_DATA=0 immediately, without waiting for a clock edge.
  - After release, in_ready=1 and words_sent=0.
- Wrap: preload 65535 completed handshakes (or force counter) and send one more -> words_sent=0x0000.
